// File: rtl/shift_add_mul.sv
// Iterative WIDTH x WIDTH unsigned shift-add multiplier: low product bits plus overflow flag.
// Latency WIDTH cycles (data-dependent with MUL_EARLY_EXIT_EN); Start is ignored while Busy or Done.
module shift_add_mul #(
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
  logic [WIDTH-1:0]   mplr, mplr_nxt;
  logic [CW-1:0]      cnt;
  logic               last_step;

  // Accumulator never wraps: the full 2*WIDTH product always fits.
  always_comb begin
    acc_nxt  = mplr[0] ? (acc + mcand) : acc;
    mplr_nxt = mplr >> 1;
`ifdef MUL_EARLY_EXIT_EN
    last_step = (cnt == CNT_LAST) || (mplr_nxt == '0);
`else
    last_step = (cnt == CNT_LAST);
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mcand    <= '0;
      mplr     <= '0;
      acc      <= '0;
      cnt      <= '0;
      Result   <= '0;
      Overflow <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Busy <= (state_nxt == RUN);
      Done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (Start) begin
            mcand <= {{WIDTH{1'b0}}, OpA};
            mplr  <= OpB;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          mcand <= mcand << 1;
          mplr  <= mplr_nxt;
          cnt   <= cnt + CW'(1);
          // Outputs take the post-add accumulator so the final step is included.
          if (last_step) begin
            Result   <= acc_nxt[WIDTH-1:0];
            Overflow <= |acc_nxt[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mul.sv
// Randomised scoreboard bench for shift_add_mul; expected products and timing from an arithmetic model.
module tb_shift_add_mul;
  localparam int W = 64;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         Start = 1'b0;
  logic [W-1:0] OpA = '0;
  logic [W-1:0] OpB = '0;
  logic         Busy, Done, Overflow;
  logic [W-1:0] Result;

  always #5 Clk = ~Clk;

  shift_add_mul #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .OpA(OpA), .OpB(OpB),
    .Busy(Busy), .Done(Done), .Result(Result), .Overflow(Overflow)
  );

  typedef struct { logic [W-1:0] res; logic ovf; } exp_t;
  exp_t sb[$];

  int cmp_cnt = 0;
  int err_cnt = 0;

  int n = 0;
  int free_at = 0;
  int busy_start = -1;
  int busy_end = -1;
  int lat;
  logic [2*W-1:0] prod;
  logic busy_exp = 1'b0;
  logic done_exp = 1'b0;
  logic [W-1:0] exp_res = '0;
  logic exp_ovf = 1'b0;

  task automatic check(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, n);
    end
  endtask

  task automatic check1(string nm, logic act, logic exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0b expected %0b (edge %0d)", nm, act, exp, n);
    end
  endtask

  // Cycles from acceptance to completion.
  function automatic int lat_of(logic [W-1:0] b);
    int hb = 0;
    for (int i = 0; i < W; i++) if (b[i]) hb = i + 1;
`ifdef MUL_EARLY_EXIT_EN
    return (hb < 1) ? 1 : hb;
`else
    return (hb > W) ? hb : W;
`endif
  endfunction

  // Reference: availability window and exact product per accepted request.
  always @(posedge Clk) begin
    n++;
    if (!Rst_n) begin
      sb.delete();
      free_at    = n + 1;
      busy_start = -1;
      busy_end   = -1;
    end else if (Start && n >= free_at) begin
      prod = {{W{1'b0}}, OpA} * {{W{1'b0}}, OpB};
      lat  = lat_of(OpB);
      sb.push_back('{res: prod[W-1:0], ovf: |prod[2*W-1:W]});
      busy_start = n;
      busy_end   = n + lat;
      free_at    = n + lat + 2;
    end
    busy_exp = (n >= busy_start) && (n < busy_end);
    done_exp = (n == busy_end);
  end

  // Monitor: compares outputs shortly after every edge.
  always @(posedge Clk) begin
    #1;
    if (!Rst_n) begin
      exp_res = '0;
      exp_ovf = 1'b0;
    end
    check1("busy", Busy, busy_exp);
    check1("done", Done, done_exp);
    if (Done) begin
      if (sb.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL done_unexpected: got Done=1 expected no pending request (edge %0d)", n);
      end else begin
        exp_t e;
        e = sb.pop_front();
        exp_res = e.res;
        exp_ovf = e.ovf;
      end
    end
    check("result", Result, exp_res);
    check1("overflow", Overflow, exp_ovf);
  end

  task automatic cyc(int k);
    repeat (k) @(negedge Clk);
  endtask

  task automatic issue(logic [W-1:0] a, logic [W-1:0] b);
    int g = 0;
    while (n + 1 < free_at && g < 500) begin
      @(negedge Clk);
      g++;
    end
    check1("issue_wait_bound", (g < 500), 1'b1);
    OpA   = a;
    OpB   = b;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((sb.size() != 0 || n < free_at) && g < 300) begin
      @(negedge Clk);
      g++;
    end
    check1("drain_empty", (sb.size() == 0), 1'b1);
  endtask

  initial begin
    #1000000;
    err_cnt++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    cyc(3);
    Rst_n = 1'b1;
    cyc(2);

    issue(64'd1024, 64'd3);                          drain();
    issue(64'h8000_0000_0000_0000, 64'd2);           drain();
    issue(64'h0000_0000_FFFF_FFFF, 64'h1_0000_0001); drain();
    issue(64'd256, 64'd0);                           drain();

    // Second Start and operand churn while the first request runs.
    issue(64'd4, 64'd5);
    cyc(8);
    OpA = 64'd9; OpB = 64'd9; Start = 1'b1;
    cyc(1);
    Start = 1'b0;
    drain();

    // Reset mid-operation aborts without a Done.
    issue(64'h1234, 64'hFFFF_0000_0000_FFFF);
    cyc(29);
    Rst_n = 1'b0;
    #1;
    check1("rst_busy", Busy, 1'b0);
    check1("rst_done", Done, 1'b0);
    check("rst_result", Result, '0);
    check1("rst_overflow", Overflow, 1'b0);
    cyc(2);
    Rst_n = 1'b1;
    cyc(1);
    issue(64'd7, 64'd6); drain();

    // Start held high: back-to-back acceptance.
    OpA = 64'd3; OpB = 64'd4; Start = 1'b1;
    cyc(200);
    Start = 1'b0;
    drain();

    for (int i = 0; i < 25; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      b = b >> $urandom_range(W - 1, 0);
      if ($urandom_range(3, 0) == 0) b = '0;
      cyc($urandom_range(3, 0));
      issue(a, b);
      OpA = {$urandom, $urandom};
      OpB = {$urandom, $urandom};
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
